// File: rtl/hazard3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hazard3_rr_arbiter
// Brief    : Registered round-robin arbiter with held grant tenures.
//            Grants one requester at a time, holds the grant until done or
//            withdrawal, and then rotates priority past the last winner.
//            Optional tenure limit: define HAZARD3_RR_ARB_TENURE_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard3_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int W_IDX      = 2,
  parameter int MAX_TENURE = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             preempt
);

  // Reject inconsistent configurations at elaboration time.
  if (W_IDX != $clog2(N_REQ) || N_REQ < 2 || MAX_TENURE < 1 || MAX_TENURE > 65535) begin : g_param_check
    $error("hazard3_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  state_t           r_state;
  logic [W_IDX-1:0] r_ptr;

  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_masked;
  logic [W_IDX-1:0] w_winner;
  logic             w_any;
  logic             w_withdraw;
  logic             w_force;
  logic             w_release;
  logic             w_load;
  logic             w_preempt;

  // Candidate set excludes the current grantee, so a released requester
  // cannot immediately win again; pick the lowest candidate above the
  // pointer, otherwise wrap to the lowest candidate overall.
  always_comb begin
    w_cand   = (r_state == ST_GRANTED) ? (req & ~gnt) : req;
    w_masked = '0;
    w_winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i > int'(r_ptr)) w_masked[i] = w_cand[i];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_masked != '0) begin
        if (w_masked[i]) w_winner = W_IDX'(i);
      end else if (w_cand[i]) begin
        w_winner = W_IDX'(i);
      end
    end
  end

  assign w_any      = |w_cand;
  assign w_withdraw = ~|(req & gnt);
  assign w_release  = (r_state == ST_GRANTED) && (done || w_withdraw || w_force);
  assign w_load     = ((r_state == ST_IDLE) && w_any) || (w_release && w_any);
  // Preempt flags only releases caused purely by the tenure limit.
  assign w_preempt  = w_force && !done && !w_withdraw;

`ifdef HAZARD3_RR_ARB_TENURE_LIMIT_EN
  localparam logic [15:0] c_tenure_last = 16'(MAX_TENURE - 1);

  logic [15:0] r_tenure;

  // Tenure counter: cleared on each new grant, counts granted cycles, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tenure <= '0;
    end else if (w_load) begin
      r_tenure <= '0;
    end else if (r_state == ST_GRANTED && r_tenure != 16'hffff) begin
      r_tenure <= r_tenure + 16'd1;
    end
  end

  // Force a release only when someone else is waiting for the port.
  assign w_force = (r_state == ST_GRANTED) && (r_tenure == c_tenure_last) && w_any;
`else
  assign w_force = 1'b0;
`endif

  // Grant state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= W_IDX'(N_REQ - 1);
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      preempt <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state  <= ST_GRANTED;
            r_ptr    <= w_winner;
            gnt      <= '0;
            gnt[w_winner] <= 1'b1;
            gnt_idx  <= w_winner;
            gnt_vld  <= 1'b1;
          end
        end
        ST_GRANTED: begin
          if (w_release) begin
            if (w_any) begin
              r_ptr   <= w_winner;
              gnt     <= '0;
              gnt[w_winner] <= 1'b1;
              gnt_idx <= w_winner;
              preempt <= w_preempt;
            end else begin
              r_state <= ST_IDLE;
              gnt     <= '0;
              gnt_idx <= '0;
              gnt_vld <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          gnt     <= '0;
          gnt_idx <= '0;
          gnt_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
